// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared funct3 encodings, sequencer state type and legality
//               helper for the branch resolution sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } br_state_t;

    function automatic logic is_legal_branch(input logic [2:0] funct3);
        logic legal;
        legal = 1'b0;
        case (funct3)
            F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : Combinational branch condition evaluation from the flags of
//               an rs1 - rs2 subtract (carry set means no borrow).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_unit
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       z,
    input  logic       n,
    input  logic       v,
    input  logic       c,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = z;
            F3_BNE:  taken = ~z;
            F3_BLT:  taken = n ^ v;
            F3_BGE:  taken = ~(n ^ v);
            F3_BLTU: taken = ~c;
            F3_BGEU: taken = c;
            default: taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_seq_ctrl
// Description : Multi-cycle branch resolution sequencer borrowing the shared
//               ALU for the compare; emits redirect/flush and counts takens.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_seq_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_funct3,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    input  logic [XLEN-1:0]  br_rs1,
    input  logic [XLEN-1:0]  br_rs2,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic             alu_sub,
    input  logic             alu_flags_valid,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    input  logic             alu_c,
    output logic             resp_valid,
    output logic             resp_taken,
    output logic [XLEN-1:0]  resp_pc,
    output logic             flush,
    output logic             err_timeout,
    output logic             err_illegal,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

    br_state_t         r_state;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [TO_W-1:0]   r_to_cnt;
    logic              w_taken;

    branch_unit u_branch_unit (
        .funct3 (r_funct3),
        .z      (alu_z),
        .n      (alu_n),
        .v      (alu_v),
        .c      (alu_c),
        .taken  (w_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_funct3    <= 3'b000;
            r_pc        <= '0;
            r_imm       <= '0;
            r_to_cnt    <= '0;
            br_ready    <= 1'b0;
            alu_req     <= 1'b0;
            alu_sub     <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            resp_valid  <= 1'b0;
            resp_taken  <= 1'b0;
            resp_pc     <= '0;
            flush       <= 1'b0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
            taken_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // br_ready is registered, so the first cycle out of reset is not an accept.
                    if (br_valid && br_ready) begin
                        br_ready <= 1'b0;
                        r_funct3 <= br_funct3;
                        r_pc     <= br_pc;
                        r_imm    <= br_imm;
                        if (is_legal_branch(br_funct3)) begin
                            alu_req <= 1'b1;
                            alu_sub <= 1'b1;
                            alu_a   <= br_rs1;
                            alu_b   <= br_rs2;
                            r_state <= REQ;
                        end else begin
                            resp_valid  <= 1'b1;
                            resp_taken  <= 1'b0;
                            flush       <= 1'b0;
                            err_illegal <= 1'b1;
                            resp_pc     <= br_pc + C_PC_STEP;
                            r_state     <= RESP;
                        end
                    end else begin
                        br_ready <= 1'b1;
                    end
                end

                REQ: begin
                    if (alu_gnt) begin
                        alu_req  <= 1'b0;
                        alu_sub  <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= WAIT;
                    end
                end

                WAIT: begin
                    // Flags arriving on the last allowed cycle still win over the abort.
                    if (alu_flags_valid) begin
                        resp_valid <= 1'b1;
                        resp_taken <= w_taken;
                        flush      <= w_taken;
                        resp_pc    <= w_taken ? (r_pc + r_imm) : (r_pc + C_PC_STEP);
                        r_state    <= RESP;
                    end else if (r_to_cnt == C_TO_LAST) begin
                        resp_valid  <= 1'b1;
                        resp_taken  <= 1'b0;
                        flush       <= 1'b0;
                        err_timeout <= 1'b1;
                        resp_pc     <= r_pc + C_PC_STEP;
                        r_state     <= RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (resp_taken && !(&taken_cnt)) begin
                        taken_cnt <= taken_cnt + 1'b1;
                    end
                    resp_valid  <= 1'b0;
                    resp_taken  <= 1'b0;
                    flush       <= 1'b0;
                    err_timeout <= 1'b0;
                    err_illegal <= 1'b0;
                    br_ready    <= 1'b1;
                    r_state     <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_seq_ctrl
// Description : Randomized self-checking bench for branch_seq_ctrl with a
//               behavioural ALU and resolution model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_seq_ctrl;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            br_valid;
    logic [2:0]      br_funct3;
    logic [XLEN-1:0] br_pc, br_imm, br_rs1, br_rs2;
    logic            alu_gnt, alu_flags_valid, alu_z, alu_n, alu_v, alu_c;

    logic            br_ready, alu_req, alu_sub, resp_valid, resp_taken, flush;
    logic            err_timeout, err_illegal;
    logic [XLEN-1:0] alu_a, alu_b, resp_pc;
    logic [15:0]     taken_cnt;

    logic            br_ready_s, alu_req_s, alu_sub_s, resp_valid_s, resp_taken_s, flush_s;
    logic            err_timeout_s, err_illegal_s;
    logic [XLEN-1:0] alu_a_s, alu_b_s, resp_pc_s;
    logic [1:0]      taken_cnt_s;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt_s;

    always #5 clk = ~clk;

    branch_seq_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_ready(br_ready), .br_funct3(br_funct3),
        .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1), .br_rs2(br_rs2),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sub(alu_sub), .alu_flags_valid(alu_flags_valid),
        .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
        .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_pc(resp_pc),
        .flush(flush), .err_timeout(err_timeout), .err_illegal(err_illegal),
        .taken_cnt(taken_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    branch_seq_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_ready(br_ready_s), .br_funct3(br_funct3),
        .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1), .br_rs2(br_rs2),
        .alu_req(alu_req_s), .alu_gnt(alu_gnt), .alu_a(alu_a_s), .alu_b(alu_b_s),
        .alu_sub(alu_sub_s), .alu_flags_valid(alu_flags_valid),
        .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
        .resp_valid(resp_valid_s), .resp_taken(resp_taken_s), .resp_pc(resp_pc_s),
        .flush(flush_s), .err_timeout(err_timeout_s), .err_illegal(err_illegal_s),
        .taken_cnt(taken_cnt_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shared ALU behaviour: flags of rs1 - rs2.
    task automatic alu_flags_of(input logic [31:0] a, input logic [31:0] b,
                                output logic z, output logic n, output logic v, output logic c);
        logic [32:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        z = (diff[31:0] == 32'd0);
        n = diff[31];
        c = ~diff[32];
        v = (a[31] != b[31]) && (diff[31] != a[31]);
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_reset_outputs();
        check("rst_br_ready",   {br_ready, br_ready_s}, 2'b00);
        check("rst_alu_req",    {alu_req, alu_req_s, alu_sub, alu_sub_s}, 4'b0);
        check("rst_alu_a",      alu_a | alu_a_s, 0);
        check("rst_alu_b",      alu_b | alu_b_s, 0);
        check("rst_resp",       {resp_valid, resp_taken, flush, resp_valid_s, resp_taken_s, flush_s}, 6'b0);
        check("rst_resp_pc",    resp_pc | resp_pc_s, 0);
        check("rst_err",        {err_timeout, err_illegal, err_timeout_s, err_illegal_s}, 4'b0);
        check("rst_taken_cnt",  taken_cnt, 0);
        check("rst_taken_cnt_s", taken_cnt_s, 0);
    endtask

    // One full branch transaction; flag_delay < 0 means flags are never returned.
    task automatic run_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] a, input logic [31:0] b,
                              input int gnt_delay, input int flag_delay);
        int          edges, req_cycles, wait_cycles, exp_lat;
        bit          legal, got_gnt, gnt_now, flags_seen, exp_taken;
        logic [31:0] exp_pc;
        logic        fz, fn, fv, fc;

        legal       = (f3 != 3'b010) && (f3 != 3'b011);
        flags_seen  = legal && (flag_delay >= 0) && (flag_delay < TIMEOUT);
        exp_taken   = flags_seen && ref_taken(f3, a, b);
        exp_pc      = exp_taken ? pc + imm : pc + 32'd4;
        exp_lat     = !legal ? 1 : (flags_seen ? 3 + gnt_delay + flag_delay : 2 + gnt_delay + TIMEOUT);
        alu_flags_of(a, b, fz, fn, fv, fc);

        for (int i = 0; i < 8 && !br_ready; i++) @(negedge clk);
        check("ready_before_accept", br_ready, 1);

        br_valid = 1'b1; br_funct3 = f3; br_pc = pc; br_imm = imm; br_rs1 = a; br_rs2 = b;
        @(posedge clk);
        @(negedge clk);
        br_valid = 1'b0;
        edges = 1; req_cycles = 0; wait_cycles = 0; got_gnt = 0;

        while (!resp_valid && edges < 60) begin
            gnt_now = 0;
            check("busy_ready", br_ready, 0);
            br_valid  = 1'($urandom_range(0, 1));
            br_funct3 = 3'($urandom);
            br_rs1 = $urandom; br_rs2 = $urandom; br_pc = $urandom; br_imm = $urandom;
            if (legal && !got_gnt) begin
                check("req_alu_req", alu_req, 1);
                check("req_alu_sub", alu_sub, 1);
                check("req_alu_a", alu_a, a);
                check("req_alu_b", alu_b, b);
                if (req_cycles == gnt_delay) begin
                    alu_gnt = 1'b1;
                    gnt_now = 1;
                end
                req_cycles++;
                // Flags outside WAIT must be ignored, even alongside the grant.
                if ($urandom_range(0, 1) == 1) begin
                    alu_flags_valid = 1'b1;
                    {alu_z, alu_n, alu_v, alu_c} = 4'($urandom);
                end
            end else begin
                check("wait_alu_req", alu_req, 0);
                if (legal && wait_cycles == flag_delay) begin
                    alu_flags_valid = 1'b1;
                    {alu_z, alu_n, alu_v, alu_c} = {fz, fn, fv, fc};
                end
                wait_cycles++;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            alu_gnt = 1'b0; alu_flags_valid = 1'b0; br_valid = 1'b0;
            if (gnt_now) got_gnt = 1;
        end

        check("resp_latency", edges, exp_lat);
        check("resp_valid", resp_valid, 1);
        check("resp_taken", resp_taken, exp_taken);
        check("resp_pc", resp_pc, exp_pc);
        check("resp_flush", flush, exp_taken);
        check("resp_err_timeout", err_timeout, legal && !flags_seen);
        check("resp_err_illegal", err_illegal, !legal);
        check("resp_alu_req", alu_req, 0);
        check("resp_twin", {resp_valid_s, resp_taken_s, resp_pc_s}, {resp_valid, exp_taken, exp_pc});

        if (exp_taken) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt_s != 2'd3)   m_cnt_s = m_cnt_s + 2'd1;
        end

        @(posedge clk);
        @(negedge clk);
        check("post_resp_valid", {resp_valid, flush}, 2'b00);
        check("post_br_ready", br_ready, 1);
        check("taken_cnt", taken_cnt, m_cnt);
        check("taken_cnt_sat", taken_cnt_s, m_cnt_s);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm;
        int          gd, fd;
        logic        fz, fn, fv, fc;

        rst = 1'b1; br_valid = 1'b0; br_funct3 = 3'b0; br_pc = '0; br_imm = '0;
        br_rs1 = '0; br_rs2 = '0; alu_gnt = 1'b0; alu_flags_valid = 1'b0;
        alu_z = 1'b0; alu_n = 1'b0; alu_v = 1'b0; alu_c = 1'b0;
        m_cnt = '0; m_cnt_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Directed cases.
        run_branch(3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0, 0);
        run_branch(3'b100, 32'h2000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_branch(3'b110, 32'h2000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run_branch(3'b001, 32'h300, 32'h40, 32'd7, 32'd9, 5, 2);
        run_branch(3'b000, 32'h400, 32'h8, 32'd1, 32'd1, 1, -1);
        run_branch(3'b000, 32'h500, 32'h8, 32'd3, 32'd3, 0, TIMEOUT - 1);
        run_branch(3'b010, 32'h600, 32'h8, 32'd3, 32'd3, 0, 0);
        run_branch(3'b011, 32'hFFFF_FFFC, 32'h8, 32'd3, 32'd3, 0, 0);
        run_branch(3'b111, 32'hFFFF_FFF0, 32'h20, 32'd9, 32'd2, 0, 0);
        for (int i = 0; i < 5; i++) run_branch(3'b000, 32'h700, 32'h10, 32'd4, 32'd4, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            f3  = 3'($urandom);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : a ^ (32'd1 << $urandom_range(0, 31)));
            pc  = $urandom;
            imm = $urandom;
            gd  = $urandom_range(0, 6);
            fd  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
            run_branch(f3, pc, imm, a, b, gd, fd);
        end

        // Reset while waiting for flags abandons the branch.
        for (int i = 0; i < 8 && !br_ready; i++) @(negedge clk);
        br_valid = 1'b1; br_funct3 = 3'b000; br_pc = 32'h900; br_imm = 32'h10;
        br_rs1 = 32'd6; br_rs2 = 32'd6;
        @(posedge clk); @(negedge clk);
        br_valid = 1'b0; alu_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        alu_gnt = 1'b0;
        @(posedge clk); @(negedge clk);
        check("wait_before_rst", {alu_req, resp_valid}, 2'b00);
        alu_flags_of(32'd6, 32'd6, fz, fn, fv, fc);
        rst = 1'b1; alu_flags_valid = 1'b1; {alu_z, alu_n, alu_v, alu_c} = {fz, fn, fv, fc};
        @(posedge clk); @(negedge clk);
        check_reset_outputs();
        alu_flags_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst_hold_no_resp", resp_valid, 0);
        rst = 1'b0;
        m_cnt = '0; m_cnt_s = '0;

        for (int i = 0; i < 10; i++) begin
            run_branch(3'($urandom), $urandom, $urandom, 32'd12, 32'($urandom_range(10, 14)),
                       $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
Multi-cycle branch resolution sequencer for the single-issue core. It accepts one conditional branch at a time from decode and borrows the shared ALU, which is arbitrated elsewhere, for a subtract compare. It evaluates the condition from the returned Z/N/V/Carry flags and emits a one-cycle redirect/flush response with the next PC. It holds decode off while busy and counts taken branches for performance monitoring.

Parameters:
XLEN, 32, datapath and PC width
TIMEOUT, 16, max cycles waiting for ALU flags before abort
CNT_W, 16, width of taken-branch counter (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
br_valid  in  1  decode presents a branch
br_ready  out  1  controller can accept a branch
br_funct3  in  3  branch funct3
br_pc  in  XLEN  PC of branch
br_imm  in  XLEN  sign-extended B-immediate
br_rs1  in  XLEN  operand 1
br_rs2  in  XLEN  operand 2
alu_req  out  1  request shared ALU
alu_gnt  in  1  ALU grant (single-cycle accept)
alu_a  out  XLEN  ALU operand A (rs1)
alu_b  out  XLEN  ALU operand B (rs2)
alu_sub  out  1  ALU op = subtract
alu_flags_valid  in  1  flags below valid this cycle
alu_z, alu_n, alu_v, alu_c  in  1 each  ALU flags
resp_valid  out  1  one-cycle resolution pulse
resp_taken  out  1  branch taken
resp_pc  out  XLEN  next PC
flush  out  1  flush younger stages (= resp_valid & resp_taken)
err_timeout  out  1  one-cycle pulse, ALU flags never arrived
err_illegal  out  1  one-cycle pulse, funct3 010/011
taken_cnt  out  CNT_W  saturating taken counter

Behaviour:
- The clock port is clk. Reset is rst, synchronous and active-high. On reset: state IDLE; br_ready=0 during reset, then 1; alu_req, alu_sub, resp_valid, resp_taken, flush, err_* = 0; resp_pc, alu_a, alu_b = 0; taken_cnt = 0. Reset mid-operation abandons the branch with no response and drops alu_req the next cycle.
- FSM states are IDLE, REQ, WAIT, RESP.
- IDLE: br_ready=1. On br_valid, latch funct3/pc/imm/rs1/rs2.
  - Legal funct3 (000, 001, 100, 101, 110, 111): go to REQ.
  - Illegal funct3 (010, 011, or any other non-branch encoding): go to RESP directly with taken=0 and err_illegal=1. The ALU is not requested.
- REQ: alu_req=1, alu_sub=1, alu_a/alu_b = latched operands, all held stable until alu_gnt. On alu_gnt, go to WAIT and clear the timeout counter.
- WAIT: alu_req=0. On alu_flags_valid, evaluate the condition and go to RESP.
  - Condition: BEQ Z; BNE ~Z; BLT N^V; BGE ~(N^V); BLTU ~C; BGEU C. Carry means no borrow.
  - If the counter reaches TIMEOUT-1 without flags: go to RESP with taken=0 and err_timeout=1.
- RESP, exactly one cycle: resp_valid=1. resp_pc = pc+imm if taken, else pc+4, modulo 2^XLEN (wrap-around, no overflow detection). flush = taken. If taken and taken_cnt is not all-ones, increment taken_cnt. Go to IDLE.
- br_ready=0 in REQ/WAIT/RESP. Minimum latency from accept to resp_valid is 3 cycles (gnt and flags both immediate). Throughput is 1 branch per 4 cycles.
- alu_flags_valid outside WAIT is ignored, including in the same cycle as alu_gnt. alu_gnt outside REQ is ignored.
- resp_taken, resp_pc and err_* are registered and are only meaningful while resp_valid=1.

Decomposition:
- Shared package branch_pkg:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - enum br_state_t {IDLE, REQ, WAIT, RESP}
  - function is_legal_branch(funct3)
- Sub-module: instantiate the existing combinational branch_unit for flag evaluation. No new condition-evaluation module.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, gnt and flags immediate -> resp_valid 3 cycles after accept, taken=1, resp_pc=0x120, flush=1, taken_cnt=1.
- BLT rs1=-1, rs2=1 (ALU returns N=1, V=0), then BLTU same operands (C=1) -> first taken with resp_pc=pc+imm; second not taken with resp_pc=pc+4, flush=0.
- alu_gnt withheld 5 cycles -> alu_req, alu_a and alu_b stable throughout, br_ready=0. Concurrent br_valid is not accepted.
- Flags withheld with TIMEOUT=16 -> err_timeout pulses 16 cycles after gnt with taken=0, resp_pc=pc+4. State returns to IDLE.
- funct3=010 -> alu_req never asserted, err_illegal=1, resp_valid 1 cycle after accept, taken=0.
- CNT_W=2, 5 taken branches -> taken_cnt saturates at 3. rst asserted during WAIT -> no resp_valid, all outputs reset values next cycle.
